// File: rtl/ofmap_deskew_serializer_pkg.sv
// Shared definitions for the output-feature-map deskew/serializer.
//   relu_sat   : clamps a sign-extended accumulator value to an unsigned byte
//   ser_state_e: serializer FSM states
//   NUM_PIX    : pixel count of a default-sized feature map
package ofmap_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 128;
  localparam int NUM_PIX    = DEF_WIDTH * DEF_HEIGHT;

  // Callers sign-extend their accumulator to this width, so one function
  // serves every ACC_W below 64.
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } ser_state_e;

  // Negative values become 0; anything above 255 saturates to 8'hFF.
  function automatic logic [7:0] relu_sat(input logic [SAT_IN_W-1:0] v);
    logic [7:0] res;
    if (v[SAT_IN_W-1]) begin
      res = 8'h00;
    end else if (v[SAT_IN_W-2:8] != '0) begin
      res = 8'hFF;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ofmap_deskew_serializer_if.sv
// Handshake/bus bundle between the systolic array columns, the serializer
// and the downstream feature writer.
//   i_data/i_valid : skewed per-channel accumulators from the array
//   i_ready        : downstream accept for o_data
//   o_data/o_valid : serialized byte stream
//   o_done/o_overflow/o_align_err : sticky status
// slave is the serializer side, master the side driving the array/writer.
interface ofmap_deskew_serializer_if #(
  parameter int CHANNEL = 3,
  parameter int ACC_W   = 16
);
  logic [CHANNEL-1:0][ACC_W-1:0] i_data;
  logic [CHANNEL-1:0]            i_valid;
  logic                          i_ready;
  logic [7:0]                    o_data;
  logic                          o_valid;
  logic                          o_done;
  logic                          o_overflow;
  logic                          o_align_err;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_done, o_overflow, o_align_err
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_done, o_overflow, o_align_err
  );
endinterface

// File: rtl/ofmap_deskew_serializer_fifo.sv
// Synchronous FIFO holding whole pixels (one entry = all channel bytes).
//   push/wdata : write an entry; ignored when full unless popping on the same edge
//   pop/rdata  : rdata shows the head entry; pop advances it
//   full/empty : derived from pointers that carry one extra wrap bit
// DEPTH must be a power of two and at least 2.
module ofmap_pixel_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves on the same edge:
  // the head is read combinationally before the slot is overwritten.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end
endmodule

// File: rtl/ofmap_deskew_serializer.sv
// Deskews diagonally skewed systolic-array outputs, applies ReLU + 8-bit
// saturation, buffers whole pixels and emits one byte per handshake in
// (y, x, c) order.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of ofmap_deskew_serializer_if (see that file)
module ofmap_deskew_serializer
  import ofmap_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int CHANNEL = 3,
  parameter int ACC_W   = 16,
  parameter int DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  ofmap_deskew_serializer_if.slave    bus
);
  localparam int MAP_PIX = WIDTH * HEIGHT;
  localparam int CNT_W   = $clog2(MAP_PIX + 1);
  localparam int CIDX_W  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
  localparam int DATA_W  = 8 * CHANNEL;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(MAP_PIX - 1);
  localparam logic [CIDX_W-1:0] LAST_CH  = CIDX_W'(CHANNEL - 1);

  logic [CHANNEL-1:0][ACC_W-1:0] al_data;
  logic [CHANNEL-1:0]            al_valid;

  // Channel k lags channel 0 by k cycles, so it gets CHANNEL-1-k stages;
  // the last channel is used straight from the port.
  for (genvar k = 0; k < CHANNEL; k++) begin : g_deskew
    localparam int STG = CHANNEL - 1 - k;
    if (STG == 0) begin : g_pass
      assign al_data[k]  = bus.i_data[k];
      assign al_valid[k] = bus.i_valid[k];
    end else begin : g_delay
      logic [ACC_W-1:0] sr_data_q [STG];
      logic [ACC_W-1:0] sr_data_d [STG];
      logic [STG-1:0]   sr_valid_q, sr_valid_d;

      always_comb begin
        sr_data_d[0]  = bus.i_data[k];
        sr_valid_d[0] = bus.i_valid[k];
        for (int i = 1; i < STG; i++) begin
          sr_data_d[i]  = sr_data_q[i-1];
          sr_valid_d[i] = sr_valid_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STG; i++) sr_data_q[i] <= '0;
          sr_valid_q <= '0;
        end else begin
          sr_data_q  <= sr_data_d;
          sr_valid_q <= sr_valid_d;
        end
      end

      assign al_data[k]  = sr_data_q[STG-1];
      assign al_valid[k] = sr_valid_q[STG-1];
    end
  end

  logic [CHANNEL-1:0][7:0] sat_q, sat_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    align_err_q, align_err_d;
  logic                    overflow_q, overflow_d;

  ser_state_e              state_q, state_d;
  logic [CIDX_W-1:0]       chan_idx_q, chan_idx_d;
  logic [CNT_W-1:0]        pixel_cnt_q, pixel_cnt_d;
  logic [CHANNEL-1:0][7:0] byte_q, byte_d;

  logic              push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // A pixel counts only when every aligned valid agrees; a partial set is
  // discarded and flagged.
  always_comb begin
    for (int k = 0; k < CHANNEL; k++) begin
      sat_d[k] = relu_sat({{(SAT_IN_W-ACC_W){al_data[k][ACC_W-1]}}, al_data[k]});
    end
    pix_valid_d = &al_valid;
    align_err_d = align_err_q | ((|al_valid) & ~(&al_valid));
  end

  // Once the map is complete nothing more is written, so DONE never overflows.
  always_comb begin
    push_req   = pix_valid_q && (state_q != DONE);
    fifo_push  = push_req && (!fifo_full || fifo_pop);
    overflow_d = overflow_q | (push_req & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q       <= '0;
      pix_valid_q <= 1'b0;
      align_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sat_q       <= sat_d;
      pix_valid_q <= pix_valid_d;
      align_err_q <= align_err_d;
      overflow_q  <= overflow_d;
    end
  end

  ofmap_pixel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (sat_q),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer: the last byte's accept pulls the next pixel straight from
  // the FIFO, so back-to-back pixels stream without a bubble.
  always_comb begin
    state_d     = state_q;
    chan_idx_d  = chan_idx_q;
    pixel_cnt_d = pixel_cnt_q;
    byte_d      = byte_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          byte_d     = fifo_rdata;
          chan_idx_d = '0;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (bus.i_ready) begin
          if (chan_idx_q != LAST_CH) begin
            chan_idx_d = chan_idx_q + CIDX_W'(1);
          end else begin
            pixel_cnt_d = pixel_cnt_q + CNT_W'(1);
            chan_idx_d  = '0;
            if (pixel_cnt_q == LAST_PIX) begin
              state_d = DONE;
            end else if (!fifo_empty) begin
              fifo_pop = 1'b1;
              byte_d   = fifo_rdata;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chan_idx_q  <= '0;
      pixel_cnt_q <= '0;
      byte_q      <= '0;
    end else begin
      state_q     <= state_d;
      chan_idx_q  <= chan_idx_d;
      pixel_cnt_q <= pixel_cnt_d;
      byte_q      <= byte_d;
    end
  end

  assign bus.o_valid     = (state_q == EMIT);
  assign bus.o_data      = byte_q[chan_idx_q];
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_overflow  = overflow_q;
  assign bus.o_align_err = align_err_q;
endmodule

// File: tb/tb_ofmap_deskew_serializer.sv
// Self-checking bench for ofmap_deskew_serializer on a 4x2 map, 3 channels.
// Pixels are scheduled by their channel-0 edge and driven skewed; a queue of
// expected bytes is built from the ReLU/saturation rule on integer values.
module tb_ofmap_deskew_serializer;
  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 2;
  localparam int CHANNEL   = 3;
  localparam int ACC_W     = 16;
  localparam int DEPTH     = 8;
  localparam int NUM_PIX   = WIDTH * HEIGHT;
  localparam int NUM_BYTES = NUM_PIX * CHANNEL;

  typedef struct {
    int         t0;
    int         v0;
    int         v1;
    int         v2;
    logic [2:0] mask;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ofmap_deskew_serializer_if #(.CHANNEL(CHANNEL), .ACC_W(ACC_W)) bus();

  ofmap_deskew_serializer #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .CHANNEL (CHANNEL),
    .ACC_W   (ACC_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         cyc          = 0;
  int         ready_mode   = 1;
  int         admitted     = 0;
  pix_t       sched[$];
  logic [7:0] exp_q[$];
  int         bytes_seen   = 0;
  int         model_done   = 0;
  int         first_acc    = -1;
  int         last_acc     = -1;
  logic       stall_prev   = 1'b0;
  logic [7:0] held         = 8'h00;

  function automatic int expSat(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int pixVal(pix_t p, int k);
    if (k == 0) return p.v0;
    if (k == 1) return p.v1;
    return p.v2;
  endfunction

  function automatic int mapVal(int p, int k);
    if (k == 0) return p * 40 - 60;
    if (k == 1) return p * 70;
    return 300 - p * 45;
  endfunction

  task automatic checkOutput(string name, int act, int req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic reportTimeout(string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: timed out at cycle %0d, %0d bytes still expected", name, cyc, exp_q.size());
  endtask

  // Drive the skewed inputs for the coming edge, then advance one cycle.
  task automatic applyStimulus();
    int target;
    target = cyc + 1;
    while (sched.size() > 0 && sched[0].t0 + CHANNEL - 1 < target) void'(sched.pop_front());
    bus.i_valid = '0;
    bus.i_data  = '0;
    foreach (sched[i]) begin
      for (int k = 0; k < CHANNEL; k++) begin
        if (sched[i].t0 + k == target) begin
          bus.i_valid[k] = sched[i].mask[k];
          bus.i_data[k]  = ACC_W'(pixVal(sched[i], k));
        end
      end
    end
    case (ready_mode)
      0:       bus.i_ready = 1'b0;
      1:       bus.i_ready = 1'b1;
      default: bus.i_ready = ~bus.i_ready;
    endcase
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Storage is the byte register plus DEPTH FIFO entries; only the first
  // NUM_PIX stored pixels are ever emitted.
  task automatic addPixel(int t0, int v0, int v1, int v2, logic [2:0] mask);
    pix_t p;
    p.t0 = t0; p.v0 = v0; p.v1 = v1; p.v2 = v2; p.mask = mask;
    sched.push_back(p);
    if (mask == 3'b111 && (admitted - bytes_seen / CHANNEL) < DEPTH + 1) begin
      admitted++;
      if (admitted <= NUM_PIX) begin
        for (int k = 0; k < CHANNEL; k++) exp_q.push_back(8'(expSat(pixVal(p, k))));
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    sched.delete();
    admitted   = 0;
    ready_mode = 1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic runUntilDone(string name, int budget);
    int n;
    n = 0;
    while (!(model_done != 0 && exp_q.size() == 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    if (n >= budget) reportTimeout(name);
  endtask

  task automatic runUntilEmpty(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      applyStimulus();
      n++;
    end
    if (n >= budget) reportTimeout(name);
  endtask

  // Scoreboard: every accepted byte against the expected queue, plus hold
  // stability while stalled and the done flag against the byte count.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      bytes_seen = 0;
      model_done = 0;
      stall_prev = 1'b0;
      first_acc  = -1;
      last_acc   = -1;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", int'(bus.o_valid), 1);
        checkOutput("stall_data", int'(bus.o_data), int'(held));
      end
      checkOutput("done_flag", int'(bus.o_done), model_done);
      if (model_done != 0) checkOutput("valid_after_done", int'(bus.o_valid), 0);
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL extra_byte: got %0d, required no byte (cycle %0d)", bus.o_data, cyc);
        end else begin
          checkOutput("byte", int'(bus.o_data), int'(exp_q.pop_front()));
        end
        bytes_seen++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (bytes_seen == NUM_BYTES) model_done = 1;
      end
      stall_prev = bus.o_valid && !bus.i_ready;
      held       = bus.o_data;
    end
  end

  initial begin
    int e0;
    int n;
    bus.i_data  = '0;
    bus.i_valid = '0;
    bus.i_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_valid", int'(bus.o_valid), 0);
    checkOutput("rst_data", int'(bus.o_data), 0);
    checkOutput("rst_done", int'(bus.o_done), 0);
    checkOutput("rst_overflow", int'(bus.o_overflow), 0);
    checkOutput("rst_align", int'(bus.o_align_err), 0);
    applyStimulus();
    rst = 1'b0;

    // Single pixel: 5, -3, 300 -> 5, 0, 255; first byte after E0+4
    $display("[TB] single pixel latency");
    e0 = cyc + 1;
    addPixel(e0, 5, -3, 300, 3'b111);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      case (cyc - e0)
        3: checkOutput("lat_not_yet", int'(bus.o_valid), 0);
        4: begin
          checkOutput("lat_first_valid", int'(bus.o_valid), 1);
          checkOutput("lat_byte0", int'(bus.o_data), 5);
        end
        5: checkOutput("lat_byte1", int'(bus.o_data), 0);
        6: checkOutput("lat_byte2", int'(bus.o_data), 255);
        7: checkOutput("lat_idle", int'(bus.o_valid), 0);
        default: ;
      endcase
    end

    // Full 4x2 map back-to-back, then late inputs after done
    $display("[TB] full map");
    doReset();
    e0 = cyc + 1;
    for (int p = 0; p < NUM_PIX; p++) addPixel(e0 + p, mapVal(p, 0), mapVal(p, 1), mapVal(p, 2), 3'b111);
    runUntilDone("map_run", 200);
    checkOutput("map_done", int'(bus.o_done), 1);
    checkOutput("map_no_bubbles", last_acc - first_acc, NUM_BYTES - 1);
    e0 = cyc + 1;
    addPixel(e0, 9, 9, 9, 3'b111);
    addPixel(e0 + 1, 7, 7, 7, 3'b111);
    repeat (20) applyStimulus();
    checkOutput("late_valid", int'(bus.o_valid), 0);
    checkOutput("late_overflow", int'(bus.o_overflow), 0);

    // Backpressure: 10 pixels into 1 + DEPTH storage
    $display("[TB] backpressure overflow");
    doReset();
    ready_mode = 0;
    e0 = cyc + 1;
    for (int p = 0; p < 10; p++) addPixel(e0 + p, mapVal(p + 3, 0), mapVal(p + 3, 1), mapVal(p + 3, 2), 3'b111);
    repeat (40) applyStimulus();
    checkOutput("bp_overflow", int'(bus.o_overflow), 1);
    checkOutput("bp_hold_valid", int'(bus.o_valid), 1);
    checkOutput("bp_hold_data", int'(bus.o_data), 60);
    ready_mode = 1;
    runUntilDone("bp_drain", 200);
    checkOutput("bp_done", int'(bus.o_done), 1);
    checkOutput("bp_overflow_sticky", int'(bus.o_overflow), 1);

    // Toggling ready
    $display("[TB] toggling ready");
    doReset();
    ready_mode = 2;
    e0 = cyc + 1;
    for (int p = 0; p < NUM_PIX; p++) addPixel(e0 + 8 * p, mapVal(p + 1, 0), mapVal(p + 1, 1), mapVal(p + 1, 2), 3'b111);
    runUntilDone("toggle_run", 400);
    checkOutput("toggle_done", int'(bus.o_done), 1);
    checkOutput("toggle_overflow", int'(bus.o_overflow), 0);

    // Misaligned middle pixel
    $display("[TB] misaligned pixel");
    doReset();
    e0 = cyc + 1;
    addPixel(e0, 32767, -32768, 255, 3'b111);
    addPixel(e0 + 1, 10, 20, 30, 3'b101);
    addPixel(e0 + 2, 256, 0, 1, 3'b111);
    runUntilEmpty("misalign_run", 100);
    repeat (10) applyStimulus();
    checkOutput("mis_align_err", int'(bus.o_align_err), 1);
    checkOutput("mis_bytes", bytes_seen, 6);
    checkOutput("mis_overflow", int'(bus.o_overflow), 0);
    checkOutput("mis_done", int'(bus.o_done), 0);

    // Reset after one byte of a pixel, then a fresh map
    $display("[TB] mid-pixel reset");
    doReset();
    e0 = cyc + 1;
    addPixel(e0, 7, 8, 9, 3'b111);
    addPixel(e0 + 1, 1, 2, 3, 3'b111);
    n = 0;
    while (bytes_seen < 1 && n < 50) begin
      applyStimulus();
      n++;
    end
    if (n >= 50) reportTimeout("mid_first_byte");
    rst = 1'b1;
    sched.delete();
    admitted = 0;
    applyStimulus();
    checkOutput("mid_rst_valid", int'(bus.o_valid), 0);
    checkOutput("mid_rst_data", int'(bus.o_data), 0);
    checkOutput("mid_rst_done", int'(bus.o_done), 0);
    applyStimulus();
    rst = 1'b0;
    e0 = cyc + 1;
    for (int p = 0; p < NUM_PIX; p++) addPixel(e0 + p, mapVal(p + 2, 0), mapVal(p + 2, 1), mapVal(p + 2, 2), 3'b111);
    runUntilDone("fresh_run", 200);
    checkOutput("fresh_done", int'(bus.o_done), 1);
    checkOutput("fresh_overflow", int'(bus.o_overflow), 0);
    checkOutput("fresh_align", int'(bus.o_align_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/ofmap_deskew_serializer.md
Name: ofmap_deskew_serializer

Overview:
- Sits directly downstream of the systolic array output columns and feeds the output-feature checker/writer.
- Takes CHANNEL accumulator outputs that arrive diagonally skewed: channel k of a pixel arrives k cycles after channel 0.
- Deskews each pixel, applies ReLU and 8-bit saturation, buffers whole pixels in a FIFO, and serializes them as one byte per handshake in raster order (y, x, c).

Parameters:
- WIDTH, 128, feature-map width in pixels.
- HEIGHT, 128, feature-map height in pixels.
- CHANNEL, 3, output channels per pixel (≥1).
- ACC_W, 16, accumulator width per channel, signed two's complement; must be >8.
- DEPTH, 8, pixel FIFO depth in whole pixels; must be a power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_data  in  CHANNEL×ACC_W  per-channel accumulator value, packed [CHANNEL-1:0][ACC_W-1:0].
- i_valid  in  CHANNEL  per-channel valid, skewed like i_data.
- o_data  out  8  serialized output byte.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accept; a byte transfers on an edge where o_valid&&i_ready.
- o_done  out  1  sticky; set once WIDTH*HEIGHT pixels have been fully emitted.
- o_overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- o_align_err  out  1  sticky; deskewed valids were not all equal.

Behaviour:
- Reset: all outputs 0; delay lines, FIFO, counters and FSM cleared; FSM enters IDLE. A reset mid-stream discards everything in flight. After release the next pixel counts as pixel 0.
- Deskew: channel k passes through CHANNEL-1-k register stages (data and valid); channel CHANNEL-1 gets zero stages. Aligned vector plus aligned valid is complete CHANNEL-1 edges after channel 0 is sampled.
- Align check:
  - Aligned valids all 1: pixel candidate.
  - Mixed: set o_align_err and discard that pixel.
  - All 0: idle.
- ReLU/sat stage (registered, +1 edge), per channel v:
  - v[ACC_W-1]==1 gives 0.
  - Else if v[ACC_W-2:8]!=0 gives 8'hFF.
  - Else v[7:0].
- FIFO write (+1 edge), storing CHANNEL bytes per entry:
  - If full and no pop on the same edge: drop the pixel, set o_overflow.
  - Simultaneous push and pop when full is allowed (no drop).
- Latency: channel 0 sampled at edge E0 → first byte visible on o_data after edge E0+CHANNEL+1, given an empty FIFO and IDLE.
- Serializer FSM:
  - IDLE: if FIFO non-empty, pop into the byte register set, chan_idx=0, go to EMIT.
  - EMIT: o_valid=1, o_data=byte[chan_idx]. On accept:
    - If chan_idx<CHANNEL-1: chan_idx++.
    - Else pixel_cnt++. If pixel_cnt reaches WIDTH*HEIGHT, go to DONE. Else if FIFO non-empty, pop the next pixel and stay in EMIT with chan_idx=0 (no bubble). Else go to IDLE.
  - No accept: o_data and o_valid hold stable.
  - DONE: o_valid=0, o_done=1. Further input pixels are still deskewed but discarded, with no FIFO writes. Exit only by rst.
- Width rules:
  - pixel_cnt sized $clog2(WIDTH*HEIGHT+1).
  - chan_idx sized max(1,$clog2(CHANNEL)).
  - FIFO pointers carry one extra wrap bit for full/empty.
- Sticky flags clear only on rst.

Decomposition:
- Package ofmap_pkg holds:
  - relu_sat function (ACC_W→8).
  - FSM state enum {IDLE, EMIT, DONE}.
  - Localparam NUM_PIX = WIDTH*HEIGHT.
- One sub-module: ofmap_pixel_fifo, a synchronous FIFO with parameters DEPTH and DATA_W=8*CHANNEL, push/pop/full/empty, and reset clearing the pointers.

Test Plan:
- Single pixel, skewed values ch0=5, ch1=-3, ch2=300 (ACC_W=16), i_ready=1 → bytes 5, 0, 255 on consecutive cycles; first byte after edge E0+4.
- Full 4×2 map (WIDTH=4, HEIGHT=2), 8 back-to-back skewed pixels, i_ready=1 → 24 bytes with no bubbles in raster/channel order; o_done=1 after the 24th accept; later inputs produce nothing.
- Backpressure: i_ready=0 for 40 cycles while 10 pixels stream in (DEPTH=8) → o_overflow=1. Emitted stream = pixel in the holding register + 8 FIFO entries, in order; the dropped pixel is never emitted.
- i_ready toggling 1/0 every cycle → o_data stable while stalled; no byte duplicated or lost.
- Misaligned input: ch1 valid for a pixel suppressed → o_align_err=1; that pixel is absent and neighbouring pixels are intact.
- rst asserted mid-pixel (after 1 of 3 bytes accepted) → outputs 0 next cycle; a fresh 4×2 run afterwards completes with o_done=1 and all flags 0.
